program_loader: RTL and testbench

Receive-side loader for the boot protocol: after the core has sent the 0xAA ready byte in LOAD mode, this block consumes the host's byte stream from the UART receiver, assembles big-endian 32-bit instruction words and writes them sequentially into instruction memory. It sits between `uart_rx` (byte strobe) and the instruction BRAM write port. It reports busy/done/error to the mode controller, which switches to EXEC mode on `done`.

---
 rtl/program_loader_if.sv | 28 ++
 rtl/program_loader.sv | 195 +++++++++++++++++++
 tb/tb_program_loader.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// program_loader_if: bundle carrying the byte stream from the UART receiver
// and the instruction memory write port. The loader uses the master modport;
// the surrounding environment (receiver + BRAM) uses the slave modport.
interface program_loader_if #(
    parameter int IMEM_ADDR_W = 14
);
    logic [7:0]             rx_data;
    logic                   rx_valid;
    logic [IMEM_ADDR_W-1:0] imem_addr;
    logic [31:0]            imem_din;
    logic                   imem_we;

    modport master (
        input  rx_data,
        input  rx_valid,
        output imem_addr,
        output imem_din,
        output imem_we
    );

    modport slave (
        output rx_data,
        output rx_valid,
        input  imem_addr,
        input  imem_din,
        input  imem_we
    );
endinterface

// File: rtl/program_loader.sv
// program_loader: receive-side boot loader. After start it takes a big-endian
// 32-bit word count N, then N big-endian words, and writes them to
// consecutive instruction memory addresses starting at 0.
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte over all data bytes; a mismatch raises err.
module program_loader #(
    parameter int IMEM_ADDR_W = 14
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    program_loader_if.master      bus,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [IMEM_ADDR_W:0]  words_loaded
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        ST_CSUM,
`endif
        ST_FIN
    } state_t;

    localparam logic [32:0]          CAPACITY = 33'd1 << IMEM_ADDR_W;
    localparam logic [IMEM_ADDR_W:0] WL_ONE   = 1;

    state_t                 state_q, state_d;
    logic [1:0]             byte_cnt_q, byte_cnt_d;
    logic [31:0]            len_q, len_d;
    logic [23:0]            word_q, word_d;
    logic [IMEM_ADDR_W:0]   words_loaded_q, words_loaded_d;
    logic                   imem_we_q, imem_we_d;
    logic [IMEM_ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]            imem_din_q, imem_din_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [31:0]            len_next;
    logic [31:0]            word_next;
    logic [IMEM_ADDR_W:0]   wl_next;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]             csum_q, csum_d;
`endif

    // Next-state logic: byte collection, word assembly, write issue and status.
    always_comb begin
        state_d        = state_q;
        byte_cnt_d     = byte_cnt_q;
        len_d          = len_q;
        word_d         = word_q;
        words_loaded_d = words_loaded_q;
        imem_we_d      = 1'b0;
        imem_addr_d    = imem_addr_q;
        imem_din_d     = imem_din_q;
        busy_d         = busy_q;
        done_d         = done_q;
        err_d          = err_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        csum_d         = csum_q;
`endif
        len_next  = {len_q[23:0], bus.rx_data};
        word_next = {word_q, bus.rx_data};
        wl_next   = words_loaded_q + WL_ONE;

        case (state_q)
            ST_IDLE, ST_FIN: begin
                // FIN entered from the last data write raises done one cycle later
                if (state_q == ST_FIN) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
                // start wins over a byte arriving in the same cycle
                if (start) begin
                    state_d        = ST_LEN;
                    byte_cnt_d     = 2'd0;
                    words_loaded_d = '0;
                    err_d          = 1'b0;
                    done_d         = 1'b0;
                    busy_d         = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_d         = 8'd0;
`endif
                end
            end
            ST_LEN: begin
                if (bus.rx_valid) begin
                    len_d      = len_next;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if ({1'b0, len_next} > CAPACITY) begin
                            err_d   = 1'b1;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = ST_FIN;
                        end else if (len_next == 32'd0) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                            state_d = ST_CSUM;
`else
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = ST_FIN;
`endif
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (bus.rx_valid) begin
                    word_d     = word_next[23:0];
                    byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ bus.rx_data;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        imem_we_d      = 1'b1;
                        imem_addr_d    = words_loaded_q[IMEM_ADDR_W-1:0];
                        imem_din_d     = word_next;
                        words_loaded_d = wl_next;
                        if (32'(wl_next) == len_q) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                            state_d = ST_CSUM;
`else
                            state_d = ST_FIN;
`endif
                        end
                    end
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (bus.rx_valid) begin
                    err_d   = (bus.rx_data != csum_q);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_FIN;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops any load in progress.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= ST_IDLE;
            byte_cnt_q     <= 2'd0;
            len_q          <= 32'd0;
            word_q         <= 24'd0;
            words_loaded_q <= '0;
            imem_we_q      <= 1'b0;
            imem_addr_q    <= '0;
            imem_din_q     <= 32'd0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q         <= 8'd0;
`endif
        end else begin
            state_q        <= state_d;
            byte_cnt_q     <= byte_cnt_d;
            len_q          <= len_d;
            word_q         <= word_d;
            words_loaded_q <= words_loaded_d;
            imem_we_q      <= imem_we_d;
            imem_addr_q    <= imem_addr_d;
            imem_din_q     <= imem_din_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            err_q          <= err_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q         <= csum_d;
`endif
        end
    end

    assign bus.imem_we   = imem_we_q;
    assign bus.imem_addr = imem_addr_q;
    assign bus.imem_din  = imem_din_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign words_loaded  = words_loaded_q;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: self-checking bench for program_loader with a small
// memory (8 words) so the oversize-length boundary is reachable. Expected
// writes and status come from a word-list model of the boot protocol.
module tb_program_loader;

    localparam int AW  = 3;
    localparam int CAP = 1 << AW;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, err;
    logic [AW:0]   words_loaded;

    program_loader_if #(.IMEM_ADDR_W(AW)) bus ();

    program_loader #(.IMEM_ADDR_W(AW)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .bus          (bus),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          obs_addr[$];
    logic [31:0] obs_data[$];
    logic [31:0] exp_words[$];

    // Record every cycle in which the write enable is high.
    always @(negedge clk) begin
        if (bus.imem_we) begin
            obs_addr.push_back(int'(bus.imem_addr));
            obs_data.push_back(bus.imem_din);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    function automatic bit model_err(input logic [31:0] n, input bit bad_csum);
        return ({1'b0, n} > 33'(CAP)) || (CSUM_EN && bad_csum);
    endfunction

    function automatic logic [AW:0] model_wl(input logic [31:0] n);
        return ({1'b0, n} > 33'(CAP)) ? '0 : (AW+1)'(n);
    endfunction

    // Build a load (length, random words, optional checksum) and stream it.
    task automatic send_load(input logic [31:0] n, input bit bad_csum, input int max_gap,
                             input int start_at, output bit timed_out);
        logic [7:0]  bytes[$];
        logic [7:0]  cs;
        logic [31:0] w;
        int          cnt;
        obs_addr.delete();
        obs_data.delete();
        exp_words.delete();
        cs = 8'd0;
        for (int i = 3; i >= 0; i--) bytes.push_back(n[i*8 +: 8]);
        if ({1'b0, n} <= 33'(CAP)) begin
            for (int i = 0; i < int'(n); i++) begin
                w = $urandom;
                exp_words.push_back(w);
                for (int j = 3; j >= 0; j--) begin
                    bytes.push_back(w[j*8 +: 8]);
                    cs = cs ^ w[j*8 +: 8];
                end
            end
            if (CSUM_EN) bytes.push_back(bad_csum ? (cs ^ 8'h01) : cs);
        end
        foreach (bytes[i]) begin
            if (i == start_at) start = 1'b1;
            send_byte(bytes[i]);
            start = 1'b0;
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) tick();
        end
        cnt = 0;
        while (!done && cnt < 40) begin
            tick();
            cnt++;
        end
        timed_out = !done;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'h00;
        repeat (3) tick();
        checks++;
        if ({busy, done, err, bus.imem_we} !== 4'b0000 || words_loaded !== '0 ||
            bus.imem_addr !== '0 || bus.imem_din !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_values: busy=%b done=%b err=%b we=%b wl=%0d addr=%0d din=%h, expected all zero",
                     busy, done, err, bus.imem_we, words_loaded, bus.imem_addr, bus.imem_din);
        end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_idle_ignore();
        obs_addr.delete();
        for (int i = 0; i < 6; i++) send_byte(8'($urandom));
        tick();
        checks++;
        if (obs_addr.size() != 0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_ignore: writes=%0d busy=%b done=%b, expected 0/0/0",
                     obs_addr.size(), busy, done);
        end
    endtask

    task automatic test_basic();
        logic [7:0] stream[12];
        logic [7:0] cs;
        stream = '{8'h00, 8'h00, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                   8'h01, 8'h02, 8'h03, 8'h04};
        cs = 8'd0;
        for (int i = 4; i < 12; i++) cs = cs ^ stream[i];
        obs_addr.delete();
        obs_data.delete();
        pulse_start();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_busy_rise: busy=%b done=%b, expected 1/0", busy, done);
        end
        for (int i = 0; i < 12; i++) send_byte(stream[i]);
        checks++;
        if (bus.imem_we !== 1'b1 || bus.imem_addr !== 3'd1 || bus.imem_din !== 32'h01020304 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_last_write: we=%b addr=%0d din=%h done=%b, expected 1/1/01020304/0",
                     bus.imem_we, bus.imem_addr, bus.imem_din, done);
        end
        if (CSUM_EN) send_byte(cs);
        else tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0 || words_loaded !== 4'd2 || bus.imem_we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_done: done=%b busy=%b err=%b wl=%0d we=%b, expected 1/0/0/2/0",
                     done, busy, err, words_loaded, bus.imem_we);
        end
        checks++;
        if (obs_addr.size() != 2 || obs_addr[0] != 0 || obs_data[0] !== 32'hDEADBEEF ||
            obs_addr[1] != 1 || obs_data[1] !== 32'h01020304) begin
            errors++;
            $display("[TB] FAIL basic_writes: count=%0d, expected DEADBEEF@0 01020304@1", obs_addr.size());
        end
        repeat (3) tick();
        checks++;
        if (bus.imem_addr !== 3'd1 || bus.imem_din !== 32'h01020304) begin
            errors++;
            $display("[TB] FAIL basic_hold: addr=%0d din=%h, expected 1/01020304", bus.imem_addr, bus.imem_din);
        end
    endtask

    task automatic test_zero_len();
        obs_addr.delete();
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte(8'h00);
        if (CSUM_EN) send_byte(8'h00);
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0 || obs_addr.size() != 0 || words_loaded !== '0) begin
            errors++;
            $display("[TB] FAIL zero_len: done=%b err=%b busy=%b writes=%0d wl=%0d, expected 1/0/0/0/0",
                     done, err, busy, obs_addr.size(), words_loaded);
        end
    endtask

    task automatic test_oversize();
        logic [31:0] lens[3];
        bit          to;
        lens = '{32'(CAP + 1), 32'h0100_0002, 32'hFFFF_FFFF};
        foreach (lens[k]) begin
            pulse_start();
            send_load(lens[k], 1'b0, 0, -1, to);
            checks++;
            if (to || done !== 1'b1 || err !== 1'b1 || obs_addr.size() != 0 || words_loaded !== '0) begin
                errors++;
                $display("[TB] FAIL oversize_%0d: timeout=%b done=%b err=%b writes=%0d wl=%0d, expected 0/1/1/0/0",
                         k, to, done, err, obs_addr.size(), words_loaded);
            end
        end
        pulse_start();
        send_load(32'(CAP), 1'b0, 1, -1, to);
        checks++;
        if (to || err !== 1'b0 || words_loaded !== 4'(CAP) || obs_addr.size() != CAP) begin
            errors++;
            $display("[TB] FAIL full_capacity: timeout=%b err=%b wl=%0d writes=%0d, expected 0/0/%0d/%0d",
                     to, err, words_loaded, obs_addr.size(), CAP, CAP);
        end else begin
            for (int i = 0; i < CAP; i++) begin
                checks++;
                if (obs_addr[i] != i || obs_data[i] !== exp_words[i]) begin
                    errors++;
                    $display("[TB] FAIL full_capacity_word%0d: got %h@%0d, expected %h@%0d",
                             i, obs_data[i], obs_addr[i], exp_words[i], i);
                end
            end
        end
    endtask

    task automatic test_checksum();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        logic [7:0] cks[2];
        cks = '{8'h44, 8'h45};
        foreach (cks[k]) begin
            obs_addr.delete();
            obs_data.delete();
            pulse_start();
            send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
            send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
            send_byte(cks[k]);
            checks++;
            if (done !== 1'b1 || err !== (k == 1) || obs_data.size() != 1 || obs_data[0] !== 32'h11223344) begin
                errors++;
                $display("[TB] FAIL checksum_%02h: done=%b err=%b writes=%0d, expected done=1 err=%0d 11223344@0",
                         cks[k], done, err, obs_data.size(), k);
            end
        end
`else
        bit to;
        pulse_start();
        send_load(32'd3, 1'b1, 2, -1, to);
        checks++;
        if (to || done !== 1'b1 || err !== 1'b0 || words_loaded !== 4'd3) begin
            errors++;
            $display("[TB] FAIL no_checksum_err: timeout=%b done=%b err=%b wl=%0d, expected 0/1/0/3",
                     to, done, err, words_loaded);
        end
`endif
    endtask

    task automatic test_back_to_back();
        bit to;
        pulse_start();
        send_load(32'd2, 1'b0, 0, 6, to);
        checks++;
        if (to || err !== 1'b0 || words_loaded !== 4'd2 || obs_data.size() != 2 ||
            obs_data[0] !== exp_words[0] || obs_data[1] !== exp_words[1] ||
            obs_addr[0] != 0 || obs_addr[1] != 1) begin
            errors++;
            $display("[TB] FAIL back_to_back: timeout=%b err=%b wl=%0d writes=%0d, expected 0/0/2/2",
                     to, err, words_loaded, obs_data.size());
        end
    endtask

    task automatic test_start_in_fin();
        bit to;
        start = 1'b1;
        send_byte(8'hFF);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fin_restart: busy=%b done=%b, expected 1/0", busy, done);
        end
        send_load(32'd1, 1'b0, 0, -1, to);
        checks++;
        if (to || err !== 1'b0 || words_loaded !== 4'd1 || obs_data.size() != 1 || obs_data[0] !== exp_words[0]) begin
            errors++;
            $display("[TB] FAIL fin_byte_dropped: timeout=%b err=%b wl=%0d writes=%0d, expected 0/0/1/1",
                     to, err, words_loaded, obs_data.size());
        end
    endtask

    task automatic test_reset_mid_load();
        bit to;
        pulse_start();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'hA5); send_byte(8'h5A);
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if ({busy, done, err, bus.imem_we} !== 4'b0000 || words_loaded !== '0 ||
            bus.imem_addr !== '0 || bus.imem_din !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid_load: busy=%b done=%b err=%b we=%b wl=%0d addr=%0d din=%h, expected all zero",
                     busy, done, err, bus.imem_we, words_loaded, bus.imem_addr, bus.imem_din);
        end
        tick();
        tick();
        rstn = 1'b1;
        tick();
        pulse_start();
        send_load(32'd3, 1'b0, 1, -1, to);
        checks++;
        if (to || err !== 1'b0 || words_loaded !== 4'd3 || obs_data.size() != 3 ||
            obs_data[0] !== exp_words[0] || obs_data[2] !== exp_words[2] || obs_addr[2] != 2) begin
            errors++;
            $display("[TB] FAIL load_after_reset: timeout=%b err=%b wl=%0d writes=%0d, expected 0/0/3/3",
                     to, err, words_loaded, obs_data.size());
        end
    endtask

    task automatic test_random();
        logic [31:0] n;
        bit          bad, to, ok;
        for (int it = 0; it < 8; it++) begin
            n   = (it == 7) ? 32'h8000_0003 : 32'($urandom_range(0, CAP + 2));
            bad = 1'($urandom_range(0, 1));
            pulse_start();
            send_load(n, bad, $urandom_range(0, 3), -1, to);
            ok = !to && done === 1'b1 && busy === 1'b0 && err === model_err(n, bad) &&
                 words_loaded === model_wl(n) && obs_data.size() == exp_words.size();
            for (int i = 0; i < obs_data.size() && ok; i++)
                if (obs_addr[i] != i || obs_data[i] !== exp_words[i]) ok = 1'b0;
            checks++;
            if (!ok) begin
                errors++;
                $display("[TB] FAIL random_%0d n=%0d bad=%b: timeout=%b done=%b err=%b wl=%0d writes=%0d, expected err=%b wl=%0d writes=%0d",
                         it, n, bad, to, done, err, words_loaded, obs_data.size(),
                         model_err(n, bad), model_wl(n), exp_words.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_ignore();
        test_basic();
        test_zero_len();
        test_oversize();
        test_checksum();
        test_back_to_back();
        test_start_in_fin();
        test_reset_mid_load();
        test_random();
        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
